ex_mem_stage_register: RTL and testbench
========================================

Name: ex_mem_stage_register

Overview:
- EX/MEM pipeline register of the segmented RISC-V core.
- Captures EX-stage results and control each cycle and presents them to MEM-stage consumers, including the branch/jump controller (branch, funct3, ALU result, zero flag).
- Supports stall (hold) and flush (bubble insertion), and tracks a per-stage valid bit so downstream logic never acts on bubbles.

Parameters:
- XLEN, 32, datapath width (ALU result, store data, branch target).
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk  in  1  core clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- stall_in  in  1  hold current contents (MEM stage busy).
- flush_in  in  1  replace contents with a bubble (branch taken / exception).
- valid_in  in  1  EX stage holds a real instruction.
- branch_in  in  1  M-control: conditional branch.
- mem_read_in  in  1  M-control: load.
- mem_write_in  in  1  M-control: store.
- reg_write_in  in  1  WB-control: register write enable.
- mem_to_reg_in  in  1  WB-control: writeback source select.
- func_3_bits_in  in  3  instruction funct3.
- alu_result_in  in  XLEN  ALU result / effective address.
- alu_zero_in  in  1  ALU zero flag.
- rs2_data_in  in  XLEN  store data.
- branch_target_in  in  XLEN  PC + immediate.
- rd_in  in  REG_ADDR_W  destination register.
- One registered output per input above (except stall_in and flush_in), same width, suffixed _out; includes valid_out.
- stall_cnt_out  out  32  stall-cycle counter (see Optional Feature).
- flush_cnt_out  out  32  flush-event counter (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst=1): every output is 0, including valid_out and both counters. Outputs stay at 0 while rst is held.
- Latency: 1 cycle. Inputs sampled at rising edge N appear on outputs after edge N.
- Update priority per rising edge (rst=0):
  - flush_in=1: all outputs cleared to 0 (bubble), valid_out=0. Flush beats stall.
  - flush_in=0, stall_in=1: every output holds its value.
  - Otherwise: load all fields. valid_out<=valid_in.
- Bubble gating: when valid_in=0 on a load, the control bits branch, mem_read, mem_write, reg_write and mem_to_reg load as 0. Data fields load as presented.
- Invariant: valid_out=0 implies all control outputs are 0.
- Stall held for many cycles: contents are frozen indefinitely, with no decay.
- Reset deasserted mid-stall: the first edge applies the stall and holds zeros.
- No combinational path from any input to any output.

Optional Feature:
- Macro: EX_MEM_PERF_CNT_EN.
- Defined:
  - stall_cnt_out increments on each edge with stall_in=1, flush_in=0 and valid_out=1.
  - flush_cnt_out increments on each edge with flush_in=1.
  - Both counters saturate at 32'hFFFF_FFFF and clear only on rst.
- Undefined: both ports remain and are tied to 0. No counter flops are synthesized.

Decomposition:
- Shared package segmented_pkg:
  - ex_mem_ctrl_t packed struct {branch, mem_read, mem_write, reg_write, mem_to_reg}.
  - ex_mem_t packed struct holding all data fields plus ctrl and valid.
  - Constants XLEN_DEF=32, REG_ADDR_W_DEF=5, FUNC3_W=3.
- Storage is one ex_mem_t register.
- Natural sub-module: pipe_reg_sf, a generic width-parameterised register with async reset, stall and flush.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with inputs nonzero -> all outputs 0 immediately. After release with valid_in=0, outputs stay 0.
- Load: valid_in=1, alu_result_in=32'h0000_1004, alu_zero_in=1, branch_in=1, func_3_bits_in=3'b000 -> the next cycle shows identical values and valid_out=1.
- Stall: load alu_result_in=32'hDEAD_BEEF, then stall 3 cycles while the inputs change to 32'h1 -> output stays 32'hDEAD_BEEF for 3 cycles. 32'h1 appears the cycle after stall drops. Stall_cnt=3 with the macro.
- Flush vs stall: flush_in=1 and stall_in=1 together with reg_write_out=1 previously -> next cycle all outputs 0, valid_out=0. Flush_cnt=1.
- Bubble gating: valid_in=0, mem_write_in=1, reg_write_in=1, alu_result_in=32'h20 -> mem_write_out=0, reg_write_out=0, alu_result_out=32'h20.
- Macro off: 10 stall cycles -> stall_cnt_out and flush_cnt_out read 0 throughout.

Source files
------------

// File: rtl/segmented_pkg.sv
// Shared types and widths for the segmented RISC-V core pipeline registers.
package segmented_pkg;

  localparam int unsigned XLEN_DEF       = 32;
  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned FUNC3_W        = 3;
  localparam int unsigned CNT_W          = 32;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic                      valid;
    ex_mem_ctrl_t              ctrl;
    logic [FUNC3_W-1:0]        func3;
    logic [XLEN_DEF-1:0]       alu_result;
    logic                      alu_zero;
    logic [XLEN_DEF-1:0]       rs2_data;
    logic [XLEN_DEF-1:0]       branch_target;
    logic [REG_ADDR_W_DEF-1:0] rd;
  } ex_mem_t;

endpackage

// File: rtl/pipe_reg_sf.sv
// Generic pipeline register with async active-high reset, stall (hold) and flush (clear).
module pipe_reg_sf #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Flush wins over stall so a squashed instruction never survives a busy MEM stage.
  always_comb begin
    data_d = d_i;
    if (flush_i) begin
      data_d = '0;
    end else if (stall_i) begin
      data_d = data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/ex_mem_stage_register.sv
// EX/MEM pipeline register with stall/flush, valid tracking and bubble gating.
// Optional stall/flush performance counters are enabled with EX_MEM_PERF_CNT_EN.
module ex_mem_stage_register
  import segmented_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_in,
  input  logic                  flush_in,
  input  logic                  valid_in,
  input  logic                  branch_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  reg_write_in,
  input  logic                  mem_to_reg_in,
  input  logic [FUNC3_W-1:0]    func_3_bits_in,
  input  logic [XLEN-1:0]       alu_result_in,
  input  logic                  alu_zero_in,
  input  logic [XLEN-1:0]       rs2_data_in,
  input  logic [XLEN-1:0]       branch_target_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  valid_out,
  output logic                  branch_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic                  reg_write_out,
  output logic                  mem_to_reg_out,
  output logic [FUNC3_W-1:0]    func_3_bits_out,
  output logic [XLEN-1:0]       alu_result_out,
  output logic                  alu_zero_out,
  output logic [XLEN-1:0]       rs2_data_out,
  output logic [XLEN-1:0]       branch_target_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [CNT_W-1:0]      stall_cnt_out,
  output logic [CNT_W-1:0]      flush_cnt_out
);

  localparam int unsigned STAGE_W = $bits(ex_mem_t);

  ex_mem_t ex_mem_d;
  ex_mem_t ex_mem_q;

  // Control bits are gated by valid so a bubble can never write memory or the register file.
  always_comb begin
    ex_mem_d                 = '0;
    ex_mem_d.valid           = valid_in;
    ex_mem_d.ctrl.branch     = valid_in & branch_in;
    ex_mem_d.ctrl.mem_read   = valid_in & mem_read_in;
    ex_mem_d.ctrl.mem_write  = valid_in & mem_write_in;
    ex_mem_d.ctrl.reg_write  = valid_in & reg_write_in;
    ex_mem_d.ctrl.mem_to_reg = valid_in & mem_to_reg_in;
    ex_mem_d.func3           = func_3_bits_in;
    ex_mem_d.alu_result      = XLEN_DEF'(alu_result_in);
    ex_mem_d.alu_zero        = alu_zero_in;
    ex_mem_d.rs2_data        = XLEN_DEF'(rs2_data_in);
    ex_mem_d.branch_target   = XLEN_DEF'(branch_target_in);
    ex_mem_d.rd              = REG_ADDR_W_DEF'(rd_in);
  end

  pipe_reg_sf #(
    .WIDTH (STAGE_W)
  ) u_stage_reg (
    .clk     (clk),
    .rst     (rst),
    .stall_i (stall_in),
    .flush_i (flush_in),
    .d_i     (ex_mem_d),
    .q_o     (ex_mem_q)
  );

  assign valid_out         = ex_mem_q.valid;
  assign branch_out        = ex_mem_q.ctrl.branch;
  assign mem_read_out      = ex_mem_q.ctrl.mem_read;
  assign mem_write_out     = ex_mem_q.ctrl.mem_write;
  assign reg_write_out     = ex_mem_q.ctrl.reg_write;
  assign mem_to_reg_out    = ex_mem_q.ctrl.mem_to_reg;
  assign func_3_bits_out   = ex_mem_q.func3;
  assign alu_result_out    = XLEN'(ex_mem_q.alu_result);
  assign alu_zero_out      = ex_mem_q.alu_zero;
  assign rs2_data_out      = XLEN'(ex_mem_q.rs2_data);
  assign branch_target_out = XLEN'(ex_mem_q.branch_target);
  assign rd_out            = REG_ADDR_W'(ex_mem_q.rd);

`ifdef EX_MEM_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  // Only stalls that hold a real instruction count; both counters saturate.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_in && !flush_in && ex_mem_q.valid && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_in && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_out = stall_cnt_q;
  assign flush_cnt_out = flush_cnt_q;
`else
  assign stall_cnt_out = '0;
  assign flush_cnt_out = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage_register.sv
// Directed self-checking bench for ex_mem_stage_register (counter expectations follow EX_MEM_PERF_CNT_EN).
module tb_ex_mem_stage_register;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_in, flush_in, valid_in;
  logic        branch_in, mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in;
  logic [2:0]  func_3_bits_in;
  logic [31:0] alu_result_in, rs2_data_in, branch_target_in;
  logic        alu_zero_in;
  logic [4:0]  rd_in;

  logic        valid_out, branch_out, mem_read_out, mem_write_out, reg_write_out, mem_to_reg_out;
  logic [2:0]  func_3_bits_out;
  logic [31:0] alu_result_out, rs2_data_out, branch_target_out;
  logic        alu_zero_out;
  logic [4:0]  rd_out;
  logic [31:0] stall_cnt_out, flush_cnt_out;

  int checks = 0;
  int errors = 0;

`ifdef EX_MEM_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  ex_mem_stage_register dut (
    .clk               (clk),
    .rst               (rst),
    .stall_in          (stall_in),
    .flush_in          (flush_in),
    .valid_in          (valid_in),
    .branch_in         (branch_in),
    .mem_read_in       (mem_read_in),
    .mem_write_in      (mem_write_in),
    .reg_write_in      (reg_write_in),
    .mem_to_reg_in     (mem_to_reg_in),
    .func_3_bits_in    (func_3_bits_in),
    .alu_result_in     (alu_result_in),
    .alu_zero_in       (alu_zero_in),
    .rs2_data_in       (rs2_data_in),
    .branch_target_in  (branch_target_in),
    .rd_in             (rd_in),
    .valid_out         (valid_out),
    .branch_out        (branch_out),
    .mem_read_out      (mem_read_out),
    .mem_write_out     (mem_write_out),
    .reg_write_out     (reg_write_out),
    .mem_to_reg_out    (mem_to_reg_out),
    .func_3_bits_out   (func_3_bits_out),
    .alu_result_out    (alu_result_out),
    .alu_zero_out      (alu_zero_out),
    .rs2_data_out      (rs2_data_out),
    .branch_target_out (branch_target_out),
    .rd_out            (rd_out),
    .stall_cnt_out     (stall_cnt_out),
    .flush_cnt_out     (flush_cnt_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " valid"},  32'(valid_out), 32'd0);
    chk({tag, " ctrl"},   32'({branch_out, mem_read_out, mem_write_out, reg_write_out, mem_to_reg_out}), 32'd0);
    chk({tag, " f3"},     32'(func_3_bits_out), 32'd0);
    chk({tag, " alu"},    alu_result_out, 32'd0);
    chk({tag, " zero"},   32'(alu_zero_out), 32'd0);
    chk({tag, " rs2"},    rs2_data_out, 32'd0);
    chk({tag, " tgt"},    branch_target_out, 32'd0);
    chk({tag, " rd"},     32'(rd_out), 32'd0);
    chk({tag, " scnt"},   stall_cnt_out, 32'd0);
    chk({tag, " fcnt"},   flush_cnt_out, 32'd0);
  endtask

  // Sample 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic v, input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [31:0] tgt, input logic [4:0] rd, input logic [4:0] ctrl,
                         input logic [2:0] f3, input logic z);
    valid_in         = v;
    alu_result_in    = alu;
    rs2_data_in      = rs2;
    branch_target_in = tgt;
    rd_in            = rd;
    {branch_in, mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in} = ctrl;
    func_3_bits_in   = f3;
    alu_zero_in      = z;
  endtask

  initial begin
    stall_in = 1'b0;
    flush_in = 1'b0;
    set_all(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 3'd0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk_zero("por");
    step();
    step();
    #1 rst = 1'b0;

    // Load something, then assert reset mid-cycle with nonzero inputs.
    set_all(1'b1, 32'h55, 32'h66, 32'h77, 5'd3, 5'b00010, 3'd2, 1'b1);
    step();
    chk("pre_rst alu", alu_result_out, 32'h55);
    chk("pre_rst reg_write", 32'(reg_write_out), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_zero("async_rst");
    step();
    chk_zero("rst_held");
    set_all(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 3'd0, 1'b0);
    rst = 1'b0;
    step();
    chk_zero("post_rst_bubble");

    // Plain load.
    set_all(1'b1, 32'h0000_1004, 32'h0000_00A5, 32'h0000_2000, 5'd5, 5'b10000, 3'b000, 1'b1);
    step();
    chk("load valid",  32'(valid_out), 32'd1);
    chk("load branch", 32'(branch_out), 32'd1);
    chk("load other_ctrl", 32'({mem_read_out, mem_write_out, reg_write_out, mem_to_reg_out}), 32'd0);
    chk("load alu",    alu_result_out, 32'h0000_1004);
    chk("load zero",   32'(alu_zero_out), 32'd1);
    chk("load f3",     32'(func_3_bits_out), 32'd0);
    chk("load rs2",    rs2_data_out, 32'h0000_00A5);
    chk("load tgt",    branch_target_out, 32'h0000_2000);
    chk("load rd",     32'(rd_out), 32'd5);

    // Stall for three edges while inputs change.
    set_all(1'b1, 32'hDEAD_BEEF, 32'h1111_2222, 32'h3000, 5'd9, 5'b01001, 3'b010, 1'b0);
    step();
    chk("stall_pre alu", alu_result_out, 32'hDEAD_BEEF);
    set_all(1'b1, 32'h1, 32'h2, 32'h4, 5'd1, 5'b00110, 3'b111, 1'b1);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall alu", alu_result_out, 32'hDEAD_BEEF);
      chk("stall rd",  32'(rd_out), 32'd9);
      chk("stall ctrl", 32'({branch_out, mem_read_out, mem_write_out, reg_write_out, mem_to_reg_out}), 32'b01001);
    end
    chk("stall cnt3", stall_cnt_out, CNT_EN ? 32'd3 : 32'd0);
    stall_in = 1'b0;
    step();
    chk("unstall alu", alu_result_out, 32'h1);
    chk("unstall f3",  32'(func_3_bits_out), 32'd7);

    // Flush beats stall.
    set_all(1'b1, 32'h44, 32'h45, 32'h46, 5'd7, 5'b00010, 3'd1, 1'b1);
    step();
    chk("preflush reg_write", 32'(reg_write_out), 32'd1);
    stall_in = 1'b1;
    flush_in = 1'b1;
    step();
    chk("flush valid", 32'(valid_out), 32'd0);
    chk("flush reg_write", 32'(reg_write_out), 32'd0);
    chk("flush alu", alu_result_out, 32'd0);
    chk("flush rd",  32'(rd_out), 32'd0);
    chk("flush fcnt", flush_cnt_out, CNT_EN ? 32'd1 : 32'd0);
    chk("flush scnt", stall_cnt_out, CNT_EN ? 32'd3 : 32'd0);
    stall_in = 1'b0;
    flush_in = 1'b0;

    // Bubble gating: controls cleared, data passes.
    set_all(1'b0, 32'h20, 32'h21, 32'h22, 5'd4, 5'b11111, 3'd5, 1'b1);
    step();
    chk("bubble valid", 32'(valid_out), 32'd0);
    chk("bubble mem_write", 32'(mem_write_out), 32'd0);
    chk("bubble reg_write", 32'(reg_write_out), 32'd0);
    chk("bubble ctrl", 32'({branch_out, mem_read_out, mem_to_reg_out}), 32'd0);
    chk("bubble alu", alu_result_out, 32'h20);
    chk("bubble rd",  32'(rd_out), 32'd4);

    // Long stall on a valid instruction: no decay.
    set_all(1'b1, 32'hCAFE_0001, 32'h5A5A_5A5A, 32'h8000, 5'd31, 5'b00011, 3'd4, 1'b0);
    step();
    set_all(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 3'd0, 1'b0);
    stall_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("long alu", alu_result_out, 32'hCAFE_0001);
      chk("long valid", 32'(valid_out), 32'd1);
    end
    chk("long scnt", stall_cnt_out, CNT_EN ? 32'd13 : 32'd0);
    chk("long fcnt", flush_cnt_out, CNT_EN ? 32'd1 : 32'd0);

    // Reset released while stall is held: zeros are held, counters stay cleared.
    set_all(1'b1, 32'h9999, 32'h1, 32'h2, 5'd8, 5'b11111, 3'd3, 1'b1);
    rst = 1'b1;
    #1;
    chk_zero("rst_in_stall");
    step();
    rst = 1'b0;
    step();
    chk_zero("stall_after_rst");
    step();
    chk_zero("stall_after_rst2");
    stall_in = 1'b0;
    step();
    chk("release alu", alu_result_out, 32'h9999);
    chk("release valid", 32'(valid_out), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
